// File: rtl/ahb_interconnect_slaveport.sv
// Slave-side stage of the AHB-Lite interconnect (one instance per slave).
// Arbitrates the master ports round-robin, honouring bursts and locked sequences,
// muxes the owner's address phase and the data-phase owner's write data onto the
// slave, and routes the slave's ready/response back to every master port.
module ahb_interconnect_slaveport #(
   parameter int MASTER      = 2,
   parameter int HADDR_WIDTH = 32,
   parameter int HDATA_WIDTH = 32
) (
   input  logic                                HCLK,
   input  logic                                HRESETn,
   input  logic [MASTER-1:0]                   mst_HSEL_i,
   input  logic [MASTER-1:0]                   mst_switch_i,
   input  logic [MASTER-1:0][1:0]              mst_HTRANS_i,
   input  logic [MASTER-1:0][2:0]              mst_HBURST_i,
   input  logic [MASTER-1:0][2:0]              mst_HSIZE_i,
   input  logic [MASTER-1:0]                   mst_HWRITE_i,
   input  logic [MASTER-1:0][HADDR_WIDTH-1:0]  mst_HADDR_i,
   input  logic [MASTER-1:0][HDATA_WIDTH-1:0]  mst_HWDATA_i,
   input  logic [MASTER-1:0]                   mst_HMASTLOCK_i,
   input  logic [MASTER-1:0][6:0]              mst_HPROT_i,
   input  logic [MASTER-1:0]                   mst_HNONSEC_i,
   input  logic [MASTER-1:0]                   mst_HEXCL_i,
   input  logic [MASTER-1:0][3:0]              mst_HMASTER_i,
   output logic [MASTER-1:0]                   mst_grant_o,
   output logic [MASTER-1:0]                   mst_HREADY_o,
   output logic [MASTER-1:0]                   mst_HRESP_o,
   output logic [MASTER-1:0]                   mst_HEXOKAY_o,
   output logic [HDATA_WIDTH-1:0]              mst_HRDATA_o,
   output logic                                HSEL_o,
   output logic [1:0]                          HTRANS_o,
   output logic [2:0]                          HBURST_o,
   output logic [2:0]                          HSIZE_o,
   output logic                                HWRITE_o,
   output logic [HADDR_WIDTH-1:0]              HADDR_o,
   output logic [HDATA_WIDTH-1:0]              HWDATA_o,
   output logic                                HMASTLOCK_o,
   output logic [6:0]                          HPROT_o,
   output logic                                HNONSEC_o,
   output logic                                HEXCL_o,
   output logic [3:0]                          HMASTER_o,
   output logic                                HREADY_o,
   input  logic                                HREADYOUT_i,
   input  logic                                HRESP_i,
   input  logic                                HEXOKAY_i,
   input  logic [HDATA_WIDTH-1:0]              HRDATA_i
);

   localparam int MW = (MASTER == 1) ? 1 : $clog2(MASTER);
   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   logic [MASTER-1:0] addr_owner;
   logic [MASTER-1:0] next_grant;
   logic [MW-1:0]     own_idx;
   logic [MW-1:0]     next_idx;
   logic [MW-1:0]     data_owner;
   logic [MW-1:0]     rr_ptr;
   logic              data_valid;
   logic              own_valid;
   logic              found;
   logic              arb_en;

   assign mst_grant_o  = addr_owner;
   assign own_valid    = |addr_owner;
   assign HREADY_o     = HREADYOUT_i;
   assign mst_HRDATA_o = HRDATA_i;

   // Convert the one-hot address owner into an index for the muxes
   always_comb begin
      own_idx = '0;
      for (int m = 0; m < MASTER; m++) begin
         if (addr_owner[m]) own_idx = MW'(m);
      end
   end

   // Re-arbitrate only when the slave is ready and the owner is idle or at an unlocked boundary
   always_comb begin
      arb_en = HREADYOUT_i & (~own_valid | ~mst_HSEL_i[own_idx] |
                              (mst_switch_i[own_idx] & ~mst_HMASTLOCK_i[own_idx]));
   end

   // Round-robin search starting just after the last owner; the last owner is checked last
   always_comb begin
      int idx;
      idx        = 0;
      next_grant = '0;
      next_idx   = rr_ptr;
      found      = 1'b0;
      for (int k = 1; k <= MASTER; k++) begin
         idx = (int'(rr_ptr) + k) % MASTER;
         if (!found && mst_HSEL_i[idx]) begin
            found            = 1'b1;
            next_grant[idx]  = 1'b1;
            next_idx         = MW'(idx);
         end
      end
   end

   // Address-phase owner and round-robin pointer; the pointer keeps its value when nobody requests
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_owner <= '0;
         rr_ptr     <= '0;
      end else if (arb_en) begin
         addr_owner <= next_grant;
         if (found) rr_ptr <= next_idx;
      end
   end

   // Data-phase owner follows an accepted NONSEQ/SEQ address phase by one cycle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         data_owner <= '0;
         data_valid <= 1'b0;
      end else if (HREADYOUT_i) begin
         if (HSEL_o && HTRANS_o[1]) begin
            data_owner <= own_idx;
            data_valid <= 1'b1;
         end else begin
            data_valid <= 1'b0;
         end
      end
   end

   // Slave-side address/control mux from the owner; everything quiet without an owner
   always_comb begin
      HSEL_o      = |(addr_owner & mst_HSEL_i);
      HTRANS_o    = HTRANS_IDLE;
      HBURST_o    = '0;
      HSIZE_o     = '0;
      HWRITE_o    = 1'b0;
      HADDR_o     = '0;
      HMASTLOCK_o = 1'b0;
      HPROT_o     = '0;
      HNONSEC_o   = 1'b0;
      HEXCL_o     = 1'b0;
      HMASTER_o   = '0;
      if (HSEL_o) HTRANS_o = mst_HTRANS_i[own_idx];
      if (own_valid) begin
         HBURST_o    = mst_HBURST_i[own_idx];
         HSIZE_o     = mst_HSIZE_i[own_idx];
         HWRITE_o    = mst_HWRITE_i[own_idx];
         HADDR_o     = mst_HADDR_i[own_idx];
         HMASTLOCK_o = mst_HMASTLOCK_i[own_idx];
         HPROT_o     = mst_HPROT_i[own_idx];
         HNONSEC_o   = mst_HNONSEC_i[own_idx];
         HEXCL_o     = mst_HEXCL_i[own_idx];
         HMASTER_o   = mst_HMASTER_i[own_idx];
      end
   end

   // Write data comes from the data-phase owner, overlapping the next owner's address phase
   always_comb begin
      HWDATA_o = '0;
      if (data_valid) HWDATA_o = mst_HWDATA_i[data_owner];
   end

   // Per-port responses: owners see the slave, waiting requesters are stalled, others see ready
   always_comb begin
      logic data_hit;
      data_hit      = 1'b0;
      mst_HREADY_o  = '1;
      mst_HRESP_o   = '0;
      mst_HEXOKAY_o = '0;
      for (int m = 0; m < MASTER; m++) begin
         data_hit = data_valid && (data_owner == MW'(m));
         if (data_hit) begin
            mst_HRESP_o[m]   = HRESP_i;
            mst_HEXOKAY_o[m] = HEXOKAY_i;
         end
         if (!HRESETn)                      mst_HREADY_o[m] = 1'b1;
         else if (data_hit || addr_owner[m]) mst_HREADY_o[m] = HREADYOUT_i;
         else if (mst_HSEL_i[m])             mst_HREADY_o[m] = 1'b0;
         else                                mst_HREADY_o[m] = 1'b1;
      end
   end

endmodule
